// File: rtl/layer2_pkg.sv
// Shared constants, window payload layout and lane helpers for the layer-2 pool path.
package layer2_pkg;

  localparam int unsigned CH    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned PIX_W = CH * DW;
  localparam int unsigned WIN_W = 4 * DW;

  typedef logic [DW-1:0]    val_t;
  typedef logic [PIX_W-1:0] pix_t;

  // One channel's 2x2 window; tl sits in the low 16 bits.
  typedef struct packed {
    val_t br;
    val_t bl;
    val_t tr;
    val_t tl;
  } win_t;

  function automatic val_t get_lane(input pix_t px, input int unsigned k);
    return px[k*DW +: DW];
  endfunction

  function automatic pix_t put_lane(input pix_t px, input int unsigned k, input val_t v);
    pix_t r;
    r = px;
    r[k*DW +: DW] = v;
    return r;
  endfunction

endpackage

// File: rtl/layer_2_pool_window_if.sv
// Pixel-in / window-out handshake bundle of the layer-2 pool window assembler.
interface layer_2_pool_window_if;
  import layer2_pkg::*;

  logic               i_valid;
  logic               o_ready;
  pix_t               i_data;
  logic               o_valid;
  logic               i_ready;
  logic [WIN_W-1:0]   o_data_0;
  logic [WIN_W-1:0]   o_data_1;
  logic [WIN_W-1:0]   o_data_2;
  logic [WIN_W-1:0]   o_data_3;
  logic [WIN_W-1:0]   o_data_4;
  logic [WIN_W-1:0]   o_data_5;
  logic [WIN_W-1:0]   o_data_6;
  logic [WIN_W-1:0]   o_data_7;
  logic               o_last;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_last,
           o_data_0, o_data_1, o_data_2, o_data_3,
           o_data_4, o_data_5, o_data_6, o_data_7
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_last,
           o_data_0, o_data_1, o_data_2, o_data_3,
           o_data_4, o_data_5, o_data_6, o_data_7
  );

endinterface

// File: rtl/pool_row_buf.sv
// One-row pixel store: single write port, two combinational read ports.
module pool_row_buf
  import layer2_pkg::*;
#(
  parameter int unsigned DEPTH = 24,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pix_t          wdata,
  input  logic [AW-1:0] raddr_a,
  output pix_t          rdata_a,
  input  logic [AW-1:0] raddr_b,
  output pix_t          rdata_b
);

  pix_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/layer_2_pool_window.sv
// Assembles 2x2 pooling windows from a raster pixel stream: even rows are buffered,
// odd rows pair with them and a window leaves on every odd-row/odd-column pixel.
module layer_2_pool_window
  import layer2_pkg::*;
#(
  parameter int unsigned IMG_W = 24,
  parameter int unsigned IMG_H = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  layer_2_pool_window_if.slave  bus
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pix_t          left_px;
  pix_t          top_l;
  pix_t          top_r;
  logic          out_valid;
  logic          out_last;
  logic          ready;
  logic          accept;
  logic          win_done;
  win_t          win_q [CH];

  // Single-stage pipeline: take a pixel whenever the output slot is free or draining.
  assign ready    = !out_valid || bus.i_ready;
  assign accept   = bus.i_valid && ready;
  assign win_done = accept && row[0] && col[0];

  pool_row_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_row_buf (
    .clk     (i_clk),
    .we      (accept && !row[0]),
    .waddr   (col),
    .wdata   (bus.i_data),
    .raddr_a (CW'(col - CW'(1))),
    .rdata_a (top_l),
    .raddr_b (col),
    .rdata_b (top_r)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col       <= '0;
      row       <= '0;
      left_px   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int unsigned k = 0; k < CH; k++) win_q[k] <= '0;
    end else begin
      // A completing pixel reloads the slot even while the previous window drains.
      if (win_done) begin
        out_valid <= 1'b1;
        out_last  <= (row == ROW_LAST) && (col == COL_LAST);
        for (int unsigned k = 0; k < CH; k++) begin
          win_q[k] <= '{br: get_lane(bus.i_data, k),
                        bl: get_lane(left_px, k),
                        tr: get_lane(top_r, k),
                        tl: get_lane(top_l, k)};
        end
      end else if (out_valid && bus.i_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (row[0] && !col[0]) left_px <= bus.i_data;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : RW'(row + RW'(1));
        end else begin
          col <= CW'(col + CW'(1));
        end
      end
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid  = out_valid;
  assign bus.o_last   = out_last;
  assign bus.o_data_0 = win_q[0];
  assign bus.o_data_1 = win_q[1];
  assign bus.o_data_2 = win_q[2];
  assign bus.o_data_3 = win_q[3];
  assign bus.o_data_4 = win_q[4];
  assign bus.o_data_5 = win_q[5];
  assign bus.o_data_6 = win_q[6];
  assign bus.o_data_7 = win_q[7];

endmodule

// File: tb/tb_layer_2_pool_window.sv
// Scoreboard bench for layer_2_pool_window: a frame-image reference model predicts windows,
// independent monitors pop and compare every window handshake.
module tb_layer_2_pool_window;
  import layer2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_2_pool_window_if bus ();
  layer_2_pool_window_if bus2 ();

  layer_2_pool_window #(.IMG_W(4), .IMG_H(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  layer_2_pool_window #(.IMG_W(2), .IMG_H(4)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  typedef struct {
    logic [8*WIN_W-1:0] d;
    logic               last;
    int                 cyc;
    bit                 strict;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  pix_t        img [2][4][4];
  int          mr[2];
  int          mc[2];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_win2 = 0;
  bit          strict_mode = 1'b1;
  bit          rnd_done = 1'b0;
  logic [63:0] log_d0[$];
  logic [63:0] log_d7[$];
  logic        log_last[$];

  always @(negedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  function automatic pix_t pixv(input int r, input int c, input int off);
    pix_t p;
    p = '0;
    for (int k = 0; k < 8; k++) p = put_lane(p, k, 16'(256*k + 16*r + c + off));
    return p;
  endfunction

  // Reference: store every pixel of the frame image; a window is the 2x2 block ending here.
  task automatic model_acc(input int inst, input pix_t px, input int c0);
    int   w;
    int   r;
    int   c;
    exp_t e;
    w = (inst == 0) ? 4 : 2;
    r = mr[inst];
    c = mc[inst];
    img[inst][r][c] = px;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      for (int k = 0; k < 8; k++)
        e.d[k*64 +: 64] = {get_lane(px, k), get_lane(img[inst][r][c-1], k),
                           get_lane(img[inst][r-1][c], k), get_lane(img[inst][r-1][c-1], k)};
      e.last   = (r == 3) && (c == w - 1);
      e.cyc    = c0;
      e.strict = strict_mode;
      if (inst == 0) q1.push_back(e);
      else q2.push_back(e);
    end
    mc[inst] = c + 1;
    if (mc[inst] == w) begin
      mc[inst] = 0;
      mr[inst] = (r + 1) % 4;
    end
  endtask

  always @(negedge clk) begin
    logic [8*WIN_W-1:0] got;
    exp_t e;
    #1;
    if (!rst && bus.o_valid && bus.i_ready) begin
      got = {bus.o_data_7, bus.o_data_6, bus.o_data_5, bus.o_data_4,
             bus.o_data_3, bus.o_data_2, bus.o_data_1, bus.o_data_0};
      log_d0.push_back(bus.o_data_0);
      log_d7.push_back(bus.o_data_7);
      log_last.push_back(bus.o_last);
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_window: got %0h expected none", bus.o_data_0);
      end else begin
        e = q1.pop_front();
        chk("win_data", 512'(got), 512'(e.d));
        chk("win_last", 512'(bus.o_last), 512'(e.last));
        if (e.strict) chk("win_latency", 512'(cyc), 512'(e.cyc + 1));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && bus2.o_valid && bus2.i_ready) begin
      n_win2++;
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_window2: got %0h expected none", bus2.o_data_0);
      end else begin
        e = q2.pop_front();
        chk("win2_data", 512'({bus2.o_data_7, bus2.o_data_6, bus2.o_data_5, bus2.o_data_4,
                              bus2.o_data_3, bus2.o_data_2, bus2.o_data_1, bus2.o_data_0}),
            512'(e.d));
        chk("win2_last", 512'(bus2.o_last), 512'(e.last));
      end
    end
  end

  task automatic send1(input pix_t px);
    int g;
    g = 0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = px;
    #1;
    while (!bus.o_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (bus.o_ready) begin
      model_acc(0, px, cyc);
      n_acc++;
    end else begin
      n_chk++;
      $display("FAIL accept_timeout: got o_ready=0 expected 1");
    end
  endtask

  task automatic send2(input pix_t px);
    int g;
    g = 0;
    @(negedge clk);
    bus2.i_valid = 1'b1;
    bus2.i_data  = px;
    #1;
    while (!bus2.o_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (bus2.o_ready) model_acc(1, px, cyc);
    else begin
      n_chk++;
      $display("FAIL accept2_timeout: got o_ready=0 expected 1");
    end
  endtask

  task automatic idle1();
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain(input int inst);
    int g;
    g = 0;
    while (((inst == 0) ? q1.size() : q2.size()) != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (((inst == 0) ? q1.size() : q2.size()) == 0) n_pass++;
    else $display("FAIL drain: got %0d pending windows expected 0", (inst == 0) ? q1.size() : q2.size());
  endtask

  task automatic clear_logs();
    log_d0.delete();
    log_d7.delete();
    log_last.delete();
  endtask

  task automatic send_frame(input int off);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) send1(pixv(r, c, off));
  endtask

  task automatic chk_zero_out(input string name);
    chk(name, 512'({bus.o_valid, bus.o_last, bus.o_data_7, bus.o_data_6, bus.o_data_5, bus.o_data_4,
                    bus.o_data_3, bus.o_data_2, bus.o_data_1, bus.o_data_0}), 512'(0));
  endtask

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    bus.i_ready  = 1'b1;
    bus2.i_valid = 1'b0;
    bus2.i_data  = '0;
    bus2.i_ready = 1'b1;
    mr = '{0, 0};
    mc = '{0, 0};
    repeat (2) @(negedge clk);
    #1;
    chk_zero_out("reset_outputs");
    chk("reset_ready", 512'(bus.o_ready), 512'(1));
    @(negedge clk);
    rst = 1'b0;

    // Free flow
    strict_mode = 1'b1;
    clear_logs();
    send_frame(0);
    idle1();
    drain(0);
    chk("ff_count", 512'(log_d0.size()), 512'(4));
    if (log_d0.size() == 4) begin
      chk("ff_first_d0", 512'(log_d0[0]), 512'(64'h0011_0010_0001_0000));
      chk("ff_first_d7", 512'(log_d7[0]), 512'(64'h0711_0710_0701_0700));
      chk("ff_last_d0", 512'(log_d0[3]), 512'(64'h0033_0032_0023_0022));
      chk("ff_last_flags", 512'({log_last[3], log_last[2], log_last[1], log_last[0]}), 512'(4'b1000));
    end

    // Backpressure on the first window
    strict_mode = 1'b0;
    clear_logs();
    @(negedge clk);
    bus.i_ready = 1'b0;
    fork
      send_frame(0);
      begin
        int g;
        int n0;
        g = 0;
        @(negedge clk);
        #1;
        while (!bus.o_valid && g < 100) begin
          @(negedge clk);
          #1;
          g++;
        end
        n0 = n_acc;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) begin
            @(negedge clk);
            #1;
          end
          chk("bp_valid_hold", 512'(bus.o_valid), 512'(1));
          chk("bp_data_hold", 512'(bus.o_data_0), 512'(64'h0011_0010_0001_0000));
          chk("bp_ready_low", 512'(bus.o_ready), 512'(0));
        end
        chk("bp_no_accept", 512'(n_acc), 512'(n0));
        @(negedge clk);
        bus.i_ready = 1'b1;
      end
    join
    idle1();
    drain(0);
    chk("bp_count", 512'(log_d0.size()), 512'(4));

    // Input bubbles
    strict_mode = 1'b1;
    clear_logs();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        idle1();
        if ($urandom_range(0, 1) == 1) idle1();
        send1(pixv(r, c, 0));
      end
    idle1();
    drain(0);
    chk("bub_count", 512'(log_d0.size()), 512'(4));

    // Back-to-back frames
    clear_logs();
    send_frame(0);
    send_frame(16'h4000);
    idle1();
    drain(0);
    chk("b2b_count", 512'(log_d0.size()), 512'(8));
    if (log_d0.size() == 8) begin
      chk("b2b_w5_d0", 512'(log_d0[4]), 512'(64'h4011_4010_4001_4000));
      chk("b2b_last_flags", 512'({log_last[7], log_last[6], log_last[5], log_last[4],
                                  log_last[3], log_last[2], log_last[1], log_last[0]}),
          512'(8'b1000_1000));
    end

    // Reset mid-frame
    for (int i = 0; i < 9; i++) send1(pixv(i / 4, i % 4, 0));
    idle1();
    drain(0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_out("midrst_outputs");
    mr[0] = 0;
    mc[0] = 0;
    clear_logs();
    send_frame(0);
    idle1();
    drain(0);
    chk("midrst_count", 512'(log_d0.size()), 512'(4));
    if (log_d0.size() == 4)
      chk("midrst_first_d0", 512'(log_d0[0]), 512'(64'h0011_0010_0001_0000));

    // Narrow image, continuous pixels
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 2; c++) send2(pixv(r, c, 0));
    @(negedge clk);
    bus2.i_valid = 1'b0;
    drain(1);
    chk("narrow_count", 512'(n_win2), 512'(2));

    // Random data, bubbles and backpressure over two frames
    strict_mode = 1'b0;
    clear_logs();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          if ($urandom_range(0, 3) == 0) idle1();
          send1({$urandom, $urandom, $urandom, $urandom});
        end
        idle1();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          bus.i_ready = ($urandom_range(0, 2) != 0);
        end
        bus.i_ready = 1'b1;
      end
    join
    drain(0);
    chk("rnd_count", 512'(log_d0.size()), 512'(8));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/layer_2_pool_window.md
Name: layer_2_pool_window

Overview:
- Window assembler that feeds the layer-2 average pool.
- Accepts the layer-2 conv feature map as a raster stream: one pixel per beat, 8 channels x 16 bit.
- Buffers one even row and, at each odd row/odd column pixel, emits a complete 2x2 window per channel as eight 64-bit lanes on a valid/ready interface.
- Each emitted window is exactly one set of pool inputs.

Parameters:
- IMG_W, 24, feature-map width in pixels; even, >= 2
- IMG_H, 24, feature-map height in pixels; even, >= 2
- CH, 8, channels per pixel; fixed at 8 for this layer
- DW, 16, bits per channel value

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  input pixel valid
- o_ready  out  1  block can accept a pixel this cycle
- i_data  in  128  pixel; channel k at [16k +: 16]
- o_valid  out  1  window valid
- i_ready  in  1  downstream accepts window
- o_data_0 .. o_data_7  out  64 each  2x2 window for channel 0..7
- o_last  out  1  qualifies the final window of a frame (with o_valid)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (i_clk, i_rst).
- Reset values (next edge with i_rst=1, regardless of activity):
  - o_valid=0, o_last=0, all o_data_k=0
  - col=0, row=0
  - Row-buffer contents are don't-care.
  - Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Input handshake:
  - Accept = i_valid && o_ready.
  - o_ready = !o_valid || i_ready, combinational single-stage pipeline.
  - Nothing changes on cycles with no accept, except output drain.
- Counters:
  - col 0..IMG_W-1 and row 0..IMG_H-1 advance only on accept.
  - col wraps to 0 and row increments at col=IMG_W-1.
  - row wraps to 0 after IMG_H-1; frames stream back to back with no gap.
- Even rows (row[0]=0): the pixel is written to rowbuf[col]. No output.
- Odd rows, even col: the pixel is held in register left_px. No output.
- Odd rows, odd col: register the window on this accept edge, for each channel k:
  - [15:0] = rowbuf[col-1][k] (top-left)
  - [31:16] = rowbuf[col][k] (top-right)
  - [47:32] = left_px[k] (bottom-left)
  - [63:48] = i_data[k] (bottom-right)
  - o_valid=1 on the next cycle; latency is 1 cycle from the bottom-right accept.
  - o_last=1 when row=IMG_H-1 and col=IMG_W-1.
- Output hold: while o_valid && !i_ready, o_data_k and o_last are held stable and o_ready=0.
- Simultaneous drain and new window: a window handshake and an accept that completes a new window in the same cycle is legal. The output register reloads and o_valid stays 1.
- Output drain: on handshake with no new window, o_valid goes 0 next cycle; o_data_k keep their last value.
- Pure data movement: no arithmetic on values, no width change.
- Window count: exactly (IMG_W/2)*(IMG_H/2) windows per frame, in raster order of pooled output.

Decomposition:
- Shared package layer2_pkg:
  - constants CH=8, DW=16, PIX_W=CH*DW=128, WIN_W=4*DW=64
  - lane-index helper functions for [16k +: 16] slicing, also used by the pool and its bench
- One sub-module: pool_row_buf.
  - IMG_W x 128 memory: 1 write port, 2 combinational read ports (addresses col-1 and col).
  - Register array, so reads are combinational.
- Top-level code: counters, left_px, output register, handshake.

Test Plan (IMG_W=4, IMG_H=4; pixel (r,c) channel k value = 256k + 16r + c):
- Free-flow, i_ready=1, i_valid=1 for 16 cycles:
  - 4 windows, each 1 cycle after pixels (1,1), (1,3), (3,1), (3,3).
  - First window: o_data_0 = 64'h0011_0010_0001_0000 and o_data_7 = 64'h0711_0710_0701_0700.
  - o_last=1 only on the 4th window (o_data_0 = 64'h0033_0032_0023_0022).
- Backpressure: i_ready=0 for 5 cycles when the first window appears.
  - o_data/o_valid held constant; o_ready=0 so no pixel accepted.
  - After i_ready=1, the remaining 3 windows match the free-flow values exactly.
- Input bubbles: i_valid toggled every other cycle (random gaps).
  - Same 4 windows, same values, each 1 cycle after its bottom-right accept.
- Back-to-back frames: 32 pixels, second frame values +0x4000.
  - 8 windows; o_last on window 4 and window 8.
  - Window 5 o_data_0 = 64'h4011_4010_4001_4000.
- Reset mid-frame: i_rst=1 for one cycle after 9 pixels, then a full frame.
  - o_valid=0 and all outputs 0 after reset.
  - Exactly 4 windows with the free-flow values; no stale window emitted.
- Simultaneous drain/load: i_ready=1, pixels continuous at IMG_W=2, IMG_H=4.
  - o_valid stays 1 across consecutive windows where applicable; no window lost or duplicated (scoreboard count = 2).
